// File: rtl/core_pkg.sv
// Shared core-level types and widths used by the memory arbiter.
package core_pkg;

   localparam int Xlen     = 32;
   localparam int MaskBits = Xlen / 8;

   // Identifies which core port issued a memory request.
   typedef enum logic {
      ArbInst = 1'b0,
      ArbData = 1'b1
   } arb_id_e;

   // Arbiter grant state: free arbitration or held on a stalled request.
   typedef enum logic {
      ArbIdle,
      ArbLocked
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter_id_fifo.sv
// Small FIFO holding the issuer ID of each accepted-but-unanswered request.
// Supports push and pop in the same cycle; Depth must be a power of two.
module id_fifo #(
   parameter int Width = 1,
   parameter int Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] din_i,
   input  logic             pop_i,
   output logic [Width-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [Width-1:0] store [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [CntW-1:0]  count;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count == CntW'(Depth));
   assign empty_o = (count == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = store[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at Depth.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (do_push) store[wr_ptr] <= din_i;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU.
// Round-robin on contention, grant held while a request is stalled
// downstream, and an ID FIFO routes in-order responses to their issuer.
module mem_arbiter
   import core_pkg::*;
#(
   parameter int MaxOutstanding = 4,
   parameter int Xlen           = core_pkg::Xlen
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              instmem_valid_i,
   output logic              instmem_ready_o,
   input  logic [Xlen-1:0]   instmem_addr_i,
   input  logic [Xlen-1:0]   instmem_wdata_i,
   input  logic [Xlen/8-1:0] instmem_wmask_i,
   output logic [Xlen-1:0]   instmem_rdata_o,
   output logic              instmem_rvalid_o,
   input  logic              datamem_valid_i,
   output logic              datamem_ready_o,
   input  logic [Xlen-1:0]   datamem_addr_i,
   input  logic [Xlen-1:0]   datamem_wdata_i,
   input  logic [Xlen/8-1:0] datamem_wmask_i,
   output logic [Xlen-1:0]   datamem_rdata_o,
   output logic              datamem_rvalid_o,
   output logic              mem_valid_o,
   input  logic              mem_ready_i,
   output logic [Xlen-1:0]   mem_addr_o,
   output logic [Xlen-1:0]   mem_wdata_o,
   output logic [Xlen/8-1:0] mem_wmask_o,
   input  logic [Xlen-1:0]   mem_rdata_i,
   input  logic              mem_rvalid_i,
   output logic              rsp_err_o
);

   arb_state_e state;
   arb_id_e    rr_last;
   arb_id_e    lock_id;
   arb_id_e    grant;
   logic       grant_valid;
   logic       accept;
   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;
   logic [0:0] head;

   // Pick the requester: locked ID wins, otherwise round-robin on a tie.
   always_comb begin
      grant = ArbInst;
      if (state == ArbLocked) begin
         grant = lock_id;
      end else if (instmem_valid_i && datamem_valid_i) begin
         grant = (rr_last == ArbInst) ? ArbData : ArbInst;
      end else if (datamem_valid_i) begin
         grant = ArbData;
      end
   end

   assign grant_valid = (grant == ArbInst) ? instmem_valid_i : datamem_valid_i;

   // Outputs are forced quiet while reset is held so a mid-transaction
   // reset never presents a request or handshake downstream.
   assign mem_valid_o     = grant_valid && !fifo_full && !rst_i;
   assign accept          = mem_valid_o && mem_ready_i;
   assign instmem_ready_o = accept && (grant == ArbInst);
   assign datamem_ready_o = accept && (grant == ArbData);

   assign mem_addr_o  = (grant == ArbInst) ? instmem_addr_i  : datamem_addr_i;
   assign mem_wdata_o = (grant == ArbInst) ? instmem_wdata_i : datamem_wdata_i;
   assign mem_wmask_o = (grant == ArbInst) ? instmem_wmask_i : datamem_wmask_i;

   assign pop              = mem_rvalid_i && !fifo_empty && !rst_i;
   assign instmem_rvalid_o = pop && (head == 1'(ArbInst));
   assign datamem_rvalid_o = pop && (head == 1'(ArbData));
   assign instmem_rdata_o  = mem_rdata_i;
   assign datamem_rdata_o  = mem_rdata_i;

   // Grant FSM: lock onto a stalled requester, round-robin pointer on accept.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ArbIdle;
         rr_last <= ArbInst;
         lock_id <= ArbInst;
      end else begin
         if (accept) begin
            state   <= ArbIdle;
            rr_last <= grant;
         end else if (state == ArbIdle && mem_valid_o) begin
            state   <= ArbLocked;
            lock_id <= grant;
         end
      end
   end

   // Sticky flag for a response arriving with nothing outstanding.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_err_o <= 1'b0;
      end else if (mem_rvalid_i && fifo_empty) begin
         rsp_err_o <= 1'b1;
      end
   end

   id_fifo #(
      .Width (1),
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (accept),
      .din_i   (1'(grant)),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with immediate-assertion checks.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        iv, dv;
   logic        iready, dready;
   logic [31:0] iaddr, daddr, iwdata, dwdata;
   logic [3:0]  iwmask, dwmask;
   logic [31:0] irdata, drdata;
   logic        irv, drv;
   logic        mvalid, mready;
   logic [31:0] maddr, mwdata;
   logic [3:0]  mwmask;
   logic [31:0] mrdata;
   logic        mrvalid;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;

   mem_arbiter #(.MaxOutstanding(4), .Xlen(32)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .instmem_valid_i  (iv),
      .instmem_ready_o  (iready),
      .instmem_addr_i   (iaddr),
      .instmem_wdata_i  (iwdata),
      .instmem_wmask_i  (iwmask),
      .instmem_rdata_o  (irdata),
      .instmem_rvalid_o (irv),
      .datamem_valid_i  (dv),
      .datamem_ready_o  (dready),
      .datamem_addr_i   (daddr),
      .datamem_wdata_i  (dwdata),
      .datamem_wmask_i  (dwmask),
      .datamem_rdata_o  (drdata),
      .datamem_rvalid_o (drv),
      .mem_valid_o      (mvalid),
      .mem_ready_i      (mready),
      .mem_addr_o       (maddr),
      .mem_wdata_o      (mwdata),
      .mem_wmask_o      (mwmask),
      .mem_rdata_i      (mrdata),
      .mem_rvalid_i     (mrvalid),
      .rsp_err_o        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks request-side handshake: mem_valid, inst ready, data ready.
   task automatic chk_req(input string tag, input logic v, input logic ir, input logic dr);
      chk1({tag, "_mvalid"}, mvalid, v);
      chk1({tag, "_iready"}, iready, ir);
      chk1({tag, "_dready"}, dready, dr);
   endtask

   // Checks response routing.
   task automatic chk_rsp(input string tag, input logic ir, input logic dr);
      chk1({tag, "_irvalid"}, irv, ir);
      chk1({tag, "_drvalid"}, drv, dr);
   endtask

   initial begin
      rst = 1'b1;
      iv = 1'b0; dv = 1'b0; mready = 1'b0; mrvalid = 1'b0;
      iaddr = '0; daddr = '0; iwdata = '0; dwdata = '0;
      iwmask = '0; dwmask = '0; mrdata = '0;
      #1;
      // Reset state
      chk_req("rst", 1'b0, 1'b0, 1'b0);
      chk_rsp("rst", 1'b0, 1'b0);
      chk1("rst_err", err, 1'b0);
      step();
      step();
      rst = 1'b0;

      // Lone fetch request, response two cycles later
      iv = 1'b1; iaddr = 32'h100; mready = 1'b1;
      #1;
      chk_req("fetch", 1'b1, 1'b1, 1'b0);
      chk32("fetch_addr", maddr, 32'h100);
      step();
      iv = 1'b0;
      #1;
      chk_req("fetch_idle", 1'b0, 1'b0, 1'b0);
      step();
      mrvalid = 1'b1; mrdata = 32'hdead_beef;
      #1;
      chk_rsp("fetch_rsp", 1'b1, 1'b0);
      chk32("fetch_rdata", irdata, 32'hdead_beef);
      step();
      mrvalid = 1'b0;

      // Contention: rr_last is INST, so data goes first, then alternate
      iv = 1'b1; dv = 1'b1; iaddr = 32'h200; daddr = 32'h300;
      #1;
      chk_req("rr0", 1'b1, 1'b0, 1'b1);
      chk32("rr0_addr", maddr, 32'h300);
      step();
      mrvalid = 1'b1;
      #1;
      chk_req("rr1", 1'b1, 1'b1, 1'b0);
      chk32("rr1_addr", maddr, 32'h200);
      chk_rsp("rr1", 1'b0, 1'b1);
      step();
      #1;
      chk_req("rr2", 1'b1, 1'b0, 1'b1);
      chk_rsp("rr2", 1'b1, 1'b0);
      step();
      #1;
      chk_req("rr3", 1'b1, 1'b1, 1'b0);
      chk_rsp("rr3", 1'b0, 1'b1);
      step();
      iv = 1'b0; dv = 1'b0;
      #1;
      chk_rsp("rr4", 1'b1, 1'b0);
      step();
      mrvalid = 1'b0;

      // Stalled data request locks the grant (rr_last is INST again)
      dv = 1'b1; daddr = 32'h400; dwdata = 32'h55; dwmask = 4'hf; mready = 1'b0;
      #1;
      chk_req("lock0", 1'b1, 1'b0, 1'b0);
      chk32("lock0_addr", maddr, 32'h400);
      step();
      iv = 1'b1; iaddr = 32'h500;
      for (int i = 1; i < 3; i++) begin
         #1;
         chk_req($sformatf("lock%0d", i), 1'b1, 1'b0, 1'b0);
         chk32($sformatf("lock%0d_addr", i), maddr, 32'h400);
         chk32($sformatf("lock%0d_wdata", i), mwdata, 32'h55);
         chk1($sformatf("lock%0d_wmask", i), (mwmask == 4'hf), 1'b1);
         step();
      end
      mready = 1'b1;
      #1;
      chk_req("lock_acc", 1'b1, 1'b0, 1'b1);
      chk32("lock_acc_addr", maddr, 32'h400);
      step();
      dv = 1'b0; mrvalid = 1'b1;
      #1;
      chk_req("after_lock", 1'b1, 1'b1, 1'b0);
      chk32("after_lock_addr", maddr, 32'h500);
      chk_rsp("after_lock", 1'b0, 1'b1);
      step();
      iv = 1'b0;
      #1;
      chk_rsp("after_lock2", 1'b1, 1'b0);
      step();
      mrvalid = 1'b0;

      // Fill all four entries: grants D,I,D,I (rr_last is INST)
      iv = 1'b1; dv = 1'b1;
      #1;
      chk_req("fill0", 1'b1, 1'b0, 1'b1);
      step();
      chk_req("fill1", 1'b1, 1'b1, 1'b0);
      step();
      chk_req("fill2", 1'b1, 1'b0, 1'b1);
      step();
      chk_req("fill3", 1'b1, 1'b1, 1'b0);
      step();
      chk_req("full", 1'b0, 1'b0, 1'b0);
      mrvalid = 1'b1;
      #1;
      chk_req("full_pop", 1'b0, 1'b0, 1'b0);
      chk_rsp("full_pop", 1'b0, 1'b1);
      step();
      // Entry freed: issue resumes while another response pops
      #1;
      chk_req("resume", 1'b1, 1'b0, 1'b1);
      chk_rsp("resume", 1'b1, 1'b0);
      step();
      mrvalid = 1'b0;
      #1;
      chk_req("refill", 1'b1, 1'b1, 1'b0);
      step();
      chk_req("full2", 1'b0, 1'b0, 1'b0);
      iv = 1'b0; dv = 1'b0; mrvalid = 1'b1;
      #1;
      chk_rsp("drain0", 1'b0, 1'b1);
      step();
      chk_rsp("drain1", 1'b1, 1'b0);
      step();
      chk_rsp("drain2", 1'b0, 1'b1);
      step();
      chk_rsp("drain3", 1'b1, 1'b0);
      chk1("drain_err", err, 1'b0);
      step();

      // Stray response with nothing outstanding
      chk_rsp("stray", 1'b0, 1'b0);
      step();
      mrvalid = 1'b0;
      #1;
      chk1("stray_err", err, 1'b1);
      step();
      chk1("stray_err_held", err, 1'b1);

      // Reset in the middle of a locked request
      dv = 1'b1; daddr = 32'h600; mready = 1'b0;
      step();
      chk_req("prelock", 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk_req("rst_lock", 1'b0, 1'b0, 1'b0);
      chk1("rst_lock_err", err, 1'b0);
      step();
      rst = 1'b0; dv = 1'b0;
      // Lock cleared and rr reset: tie goes to data, no stall
      iv = 1'b1; dv = 1'b1; mready = 1'b1;
      #1;
      chk_req("post_rst", 1'b1, 1'b0, 1'b1);
      step();
      iv = 1'b0; dv = 1'b0;
      step();
      mrvalid = 1'b1;
      #1;
      chk_rsp("post_rst_rsp", 1'b0, 1'b1);
      step();
      chk_rsp("post_rst_stray", 1'b0, 1'b0);
      step();
      mrvalid = 1'b0;
      #1;
      chk1("post_rst_err", err, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
